// File: rtl/xbar_rr_param.sv
// NPORTS x NPORTS flit crossbar with a round-robin arbiter per output and registered outputs.
// Flits with an out-of-range route are popped and discarded, and drop_cnt_o counts them.
module xbar_rr_param #(
    parameter int unsigned NPORTS  = 5,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ROUTE_W = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NPORTS-1:0]         valid_i,
    input  logic [NPORTS*ROUTE_W-1:0] route_i,
    input  logic [NPORTS*DATA_W-1:0]  data_i,
    output logic [NPORTS-1:0]         pop_req_o,
    input  logic [NPORTS-1:0]         out_ready_i,
    output logic [NPORTS-1:0]         valid_o,
    output logic [NPORTS*DATA_W-1:0]  data_o,
    output logic [7:0]                drop_cnt_o
);

    localparam int unsigned IDX_W = ROUTE_W + 1;
    localparam logic [IDX_W-1:0] NPORTS_W = IDX_W'(NPORTS);

    logic [NPORTS-1:0]        valid_q;
    logic [NPORTS*DATA_W-1:0] data_q;
    logic [ROUTE_W-1:0]       rr_ptr_q [NPORTS];
    logic [7:0]               drop_cnt_q, drop_cnt_d;

    logic [NPORTS-1:0]  req [NPORTS];  // req[o][i]: input i wants output o
    logic [NPORTS-1:0]  misroute, out_open, gnt_vld, in_gnt;
    logic [ROUTE_W-1:0] gnt_idx [NPORTS];

    always_comb begin
        logic [ROUTE_W-1:0] route;
        misroute = '0;
        for (int unsigned o = 0; o < NPORTS; o++) begin
            req[o] = '0;
        end
        for (int unsigned i = 0; i < NPORTS; i++) begin
            route       = route_i[i*ROUTE_W +: ROUTE_W];
            misroute[i] = valid_i[i] && ({1'b0, route} >= NPORTS_W);
            for (int unsigned o = 0; o < NPORTS; o++) begin
                req[o][i] = valid_i[i] && ({1'b0, route} == IDX_W'(o));
            end
        end
    end

    // First requester at or after rr_ptr, searching cyclically; closed outputs grant nothing.
    always_comb begin
        int unsigned idx;
        for (int unsigned o = 0; o < NPORTS; o++) begin
            out_open[o] = !valid_q[o] || out_ready_i[o];
            gnt_vld[o]  = 1'b0;
            gnt_idx[o]  = '0;
            for (int unsigned k = 0; k < NPORTS; k++) begin
                idx = (32'(rr_ptr_q[o]) + k) % NPORTS;
                if (out_open[o] && !gnt_vld[o] && req[o][idx]) begin
                    gnt_vld[o] = 1'b1;
                    gnt_idx[o] = ROUTE_W'(idx);
                end
            end
        end
    end

    always_comb begin
        in_gnt = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            for (int unsigned o = 0; o < NPORTS; o++) begin
                if (gnt_vld[o] && (gnt_idx[o] == ROUTE_W'(i))) begin
                    in_gnt[i] = 1'b1;
                end
            end
        end
        pop_req_o = rst ? '0 : (in_gnt | misroute);
    end

    always_comb begin
        logic [3:0] n_miss;
        logic [8:0] sum;
        n_miss = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            n_miss = n_miss + 4'(misroute[i]);
        end
        sum        = 9'(drop_cnt_q) + 9'(n_miss);
        drop_cnt_d = (sum > 9'd255) ? 8'hFF : sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            data_q     <= '0;
            drop_cnt_q <= '0;
            for (int unsigned o = 0; o < NPORTS; o++) begin
                rr_ptr_q[o] <= '0;
            end
        end else begin
            drop_cnt_q <= drop_cnt_d;
            for (int unsigned o = 0; o < NPORTS; o++) begin
                if (out_open[o]) begin
                    valid_q[o] <= gnt_vld[o];
                    if (gnt_vld[o]) begin
                        data_q[o*DATA_W +: DATA_W] <= data_i[32'(gnt_idx[o])*DATA_W +: DATA_W];
                        rr_ptr_q[o] <= ROUTE_W'((32'(gnt_idx[o]) + 1) % NPORTS);
                    end
                end
            end
        end
    end

    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_xbar_rr_param.sv
// Self-checking bench for xbar_rr_param: directed stimulus, per-output scoreboard queues
// drained whenever an output flit is accepted downstream.
module tb_xbar_rr_param;

    localparam int NP = 5;
    localparam int DW = 16;
    localparam int RW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     valid_i;
    logic [NP*RW-1:0]  route_i;
    logic [NP*DW-1:0]  data_i;
    logic [NP-1:0]     pop_req_o;
    logic [NP-1:0]     out_ready_i;
    logic [NP-1:0]     valid_o;
    logic [NP*DW-1:0]  data_o;
    logic [7:0]        drop_cnt_o;

    int n_chk = 0;
    int n_bad = 0;
    logic [15:0] exp_q [NP][$];

    xbar_rr_param #(.NPORTS(NP), .DATA_W(DW), .ROUTE_W(RW)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .route_i     (route_i),
        .data_i      (data_i),
        .pop_req_o   (pop_req_o),
        .out_ready_i (out_ready_i),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_in(input int i, input logic v, input int r, input logic [15:0] d);
        valid_i[i]          = v;
        route_i[i*RW +: RW] = RW'(r);
        data_i[i*DW +: DW]  = d;
    endtask

    function automatic logic [15:0] dat(input int i, input int n);
        return 16'(32'h4000 + i * 256 + n);
    endfunction

    // A flit is consumed when valid_o and out_ready_i are both high before the edge.
    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst) begin
            for (int o = 0; o < NP; o++) begin
                if (valid_o[o] && out_ready_i[o]) begin
                    if (exp_q[o].size() == 0) begin
                        chk("sb_extra", 80'(valid_o[o]), 80'(0));
                    end else begin
                        e = exp_q[o].pop_front();
                        chk("sb_data", 80'(data_o[o*DW +: DW]), 80'(e));
                    end
                end
            end
        end
    end

    initial begin
        int order [3];
        int sent [NP];
        int g;
        int sz;
        order = '{0, 1, 3};
        for (int i = 0; i < NP; i++) sent[i] = 0;

        rst = 1'b1; valid_i = '0; route_i = '0; data_i = '0; out_ready_i = '1;
        tick();
        valid_i = '1;
        settle();
        chk("rst_pop", 80'(pop_req_o), 80'(0));
        chk("rst_valid", 80'(valid_o), 80'(0));
        chk("rst_data", 80'(data_o), 80'(0));
        chk("rst_drop", 80'(drop_cnt_o), 80'(0));
        tick();
        valid_i = '0;
        rst = 1'b0;

        // single flit 0 -> 2
        set_in(0, 1'b1, 2, 16'hA5A5);
        settle();
        chk("t029_pop", 80'(pop_req_o), 80'(5'b00001));
        exp_q[2].push_back(16'hA5A5);
        tick();
        valid_i = '0;
        settle();
        chk("t029_vo2", 80'(valid_o[2]), 80'(1));
        chk("t029_do2", 80'(data_o[2*DW +: DW]), 80'(16'hA5A5));

        // inputs 0, 1, 3 contend for output 4
        set_in(0, 1'b1, 4, dat(0, 0));
        set_in(1, 1'b1, 4, dat(1, 0));
        set_in(3, 1'b1, 4, dat(3, 0));
        for (int c = 0; c < 6; c++) begin
            g = order[c % 3];
            settle();
            chk("t030_pop", 80'(pop_req_o), 80'(5'(1 << g)));
            exp_q[4].push_back(dat(g, sent[g]));
            tick();
            sent[g]++;
            set_in(g, 1'b1, 4, dat(g, sent[g]));
        end
        valid_i = '0;
        tick();

        // u-turn: rr_ptr[4] now points at input 4
        set_in(4, 1'b1, 4, 16'h4444);
        set_in(0, 1'b1, 4, 16'h0444);
        settle();
        chk("uturn_pop0", 80'(pop_req_o), 80'(5'b10000));
        exp_q[4].push_back(16'h4444);
        tick();
        valid_i[4] = 1'b0;
        settle();
        chk("uturn_pop1", 80'(pop_req_o), 80'(5'b00001));
        exp_q[4].push_back(16'h0444);
        tick();
        valid_i = '0;
        tick();

        // backpressure on output 1
        out_ready_i[1] = 1'b0;
        set_in(2, 1'b1, 1, 16'h1111);
        settle();
        chk("t031_pop0", 80'(pop_req_o), 80'(5'b00100));
        exp_q[1].push_back(16'h1111);
        tick();
        valid_i = '0;
        set_in(3, 1'b1, 1, 16'h2222);
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("t031_nopop", 80'(pop_req_o), 80'(0));
            chk("t031_vo1", 80'(valid_o[1]), 80'(1));
            chk("t031_hold", 80'(data_o[1*DW +: DW]), 80'(16'h1111));
            tick();
        end
        out_ready_i[1] = 1'b1;
        settle();
        chk("t031_pop1", 80'(pop_req_o), 80'(5'b01000));
        exp_q[1].push_back(16'h2222);
        tick();
        valid_i = '0;
        settle();
        chk("t031_new", 80'(data_o[1*DW +: DW]), 80'(16'h2222));
        tick();

        // permutation i -> (i+1) mod 5
        for (int i = 0; i < NP; i++) set_in(i, 1'b1, (i + 1) % NP, 16'(16'h3000 + i));
        settle();
        chk("t033_pop", 80'(pop_req_o), 80'(5'b11111));
        for (int i = 0; i < NP; i++) exp_q[(i + 1) % NP].push_back(16'(16'h3000 + i));
        tick();
        valid_i = '0;
        settle();
        chk("t033_vo", 80'(valid_o), 80'(5'b11111));
        tick();

        // misroutes: two per cycle, then one per cycle until saturation
        set_in(2, 1'b1, 7, 16'hDEAD);
        set_in(4, 1'b1, 5, 16'hBEEF);
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("t032_pop2", 80'(pop_req_o), 80'(5'b10100));
            tick();
        end
        chk("t032_drop10", 80'(drop_cnt_o), 80'(10));
        valid_i[4] = 1'b0;
        for (int c = 0; c < 300; c++) begin
            settle();
            chk("t032_pop", 80'(pop_req_o), 80'(5'b00100));
            chk("t032_vo", 80'(valid_o), 80'(0));
            tick();
        end
        chk("t032_sat", 80'(drop_cnt_o), 80'(255));
        valid_i = '0;

        // async reset with outputs 1, 2, 4 held
        out_ready_i = '0;
        set_in(0, 1'b1, 1, 16'h6001);
        set_in(1, 1'b1, 2, 16'h6002);
        set_in(3, 1'b1, 4, 16'h6004);
        settle();
        chk("t034_pop", 80'(pop_req_o), 80'(5'b01011));
        tick();
        valid_i = '1;
        settle();
        chk("t034_vo", 80'(valid_o), 80'(5'b10110));
        rst = 1'b1;
        #1;
        chk("t034_valid", 80'(valid_o), 80'(0));
        chk("t034_data", 80'(data_o), 80'(0));
        chk("t034_drop", 80'(drop_cnt_o), 80'(0));
        chk("t034_pop0", 80'(pop_req_o), 80'(0));
        tick();
        rst = 1'b0;
        valid_i = '0;
        out_ready_i = '1;
        set_in(0, 1'b1, 0, 16'h5555);
        settle();
        chk("post_rst_pop", 80'(pop_req_o), 80'(5'b00001));
        exp_q[0].push_back(16'h5555);
        tick();
        valid_i = '0;
        settle();
        chk("post_rst_vo", 80'(valid_o), 80'(5'b00001));
        tick();
        tick();

        sz = 0;
        for (int o = 0; o < NP; o++) sz += exp_q[o].size();
        chk("sb_left", 80'(sz), 80'(0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
